// File: rtl/display_mux_scan_pkg.sv
// Shared constants for the six-digit multiplexed 7-segment display path.
// Segment and anode polarities are active-low throughout.
package display_mux_scan_pkg;
    localparam int         N_DIGITS  = 6;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [5:0] AN_OFF    = 6'h3F;
endpackage

// File: rtl/display_mux_scan_tick_divider.sv
// Free-running prescaler: counts 0..CLK_DIV-1 and flags the last count.
// The same block paces the marquee's rotation step timer.
module tick_divider
    import display_mux_scan_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_presc;

    assign tick = (r_presc == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end
endmodule

// File: rtl/display_mux_scan.sv
// Time-multiplexed scan of six segment patterns onto one shared bus,
// with per-frame snapshot, brightness PWM and a blank cycle between digits.
module display_mux_scan
    import display_mux_scan_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter int BRIGHT_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_in0,
    input  logic [6:0]          seg_in1,
    input  logic [6:0]          seg_in2,
    input  logic [6:0]          seg_in3,
    input  logic [6:0]          seg_in4,
    input  logic [6:0]          seg_in5,
    input  logic                enable,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [6:0]          seg_out,
    output logic [5:0]          an_out,
    output logic                frame_start
);
    logic                w_tick;
    logic                w_capture;
    logic                w_lit;
    logic [6:0]          w_cur_seg;
    logic [2:0]          r_idx;
    logic [BRIGHT_W-1:0] r_pwm;
    logic [6:0]          r_shadow [N_DIGITS];

    tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Capture lands on the frame's final blank cycle, so no digit ever tears.
    assign w_capture = w_tick && (r_idx == 3'd5);
    assign w_lit     = (r_pwm <= brightness);

    always_comb begin
        w_cur_seg = SEG_BLANK;
        case (r_idx)
            3'd0:    w_cur_seg = r_shadow[0];
            3'd1:    w_cur_seg = r_shadow[1];
            3'd2:    w_cur_seg = r_shadow[2];
            3'd3:    w_cur_seg = r_shadow[3];
            3'd4:    w_cur_seg = r_shadow[4];
            3'd5:    w_cur_seg = r_shadow[5];
            default: w_cur_seg = SEG_BLANK;
        endcase
    end

    // Starting at 5 makes the first tick after reset a frame wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= 3'd5;
        end else if (w_tick) begin
            r_idx <= (r_idx >= 3'd5) ? 3'd0 : r_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + BRIGHT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_DIGITS; k++) r_shadow[k] <= SEG_BLANK;
        end else if (w_capture) begin
            r_shadow[0] <= seg_in0;
            r_shadow[1] <= seg_in1;
            r_shadow[2] <= seg_in2;
            r_shadow[3] <= seg_in3;
            r_shadow[4] <= seg_in4;
            r_shadow[5] <= seg_in5;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out     <= SEG_BLANK;
            an_out      <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_capture;
            if (w_tick || !enable || !w_lit) begin
                seg_out <= SEG_BLANK;
                an_out  <= AN_OFF;
            end else begin
                seg_out <= w_cur_seg;
                an_out  <= AN_OFF & ~(6'b000001 << r_idx);
            end
        end
    end
endmodule

// File: tb/tb_display_mux_scan.sv
// Scoreboard bench for display_mux_scan: a cycle-count reference model pushes
// the expected output of every edge, and each scenario pops and compares it.
module tb_display_mux_scan;
    localparam int CLK_DIV  = 4;
    localparam int BRIGHT_W = 3;

    typedef struct packed {
        logic [6:0] seg;
        logic [5:0] an;
        logic       fs;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [6:0]          seg_in [6];
    logic                enable;
    logic [BRIGHT_W-1:0] brightness;
    logic [6:0]          seg_out;
    logic [5:0]          an_out;
    logic                frame_start;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         m_cnt;
    int         m_pwm_last;
    logic [6:0] m_shadow [6];

    display_mux_scan #(.CLK_DIV(CLK_DIV), .BRIGHT_W(BRIGHT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in0     (seg_in[0]),
        .seg_in1     (seg_in[1]),
        .seg_in2     (seg_in[2]),
        .seg_in3     (seg_in[3]),
        .seg_in4     (seg_in[4]),
        .seg_in5     (seg_in[5]),
        .enable      (enable),
        .brightness  (brightness),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic int m_idx();
        return (m_cnt / CLK_DIV + 5) % 6;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int k = 0; k < 6; k++) m_shadow[k] = 7'h7F;
        q.delete();
    endtask

    // Expected output of the coming edge, derived from cycles since reset release.
    task automatic model_push();
        exp_t e;
        int   p, ix, pw;
        logic tk, lit;
        p  = m_cnt % CLK_DIV;
        ix = (m_cnt / CLK_DIV + 5) % 6;
        pw = m_cnt % (1 << BRIGHT_W);
        tk = (p == CLK_DIV - 1);
        lit = (pw <= int'(brightness));
        e.fs = tk && (ix == 5);
        if (tk || !enable || !lit) begin
            e.seg = 7'h7F;
            e.an  = 6'h3F;
        end else begin
            e.seg = m_shadow[ix];
            e.an  = ~(6'd1 << ix);
        end
        if (e.fs) for (int k = 0; k < 6; k++) m_shadow[k] = seg_in[k];
        m_pwm_last = pw;
        m_cnt++;
        q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e, obs;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (seg_out !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h want=7f", seg_out); end
        total++;
        if (an_out !== 6'h3F) begin bad++; $display("FAIL reset_an got=%h want=3f", an_out); end
        total++;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
        rst = 1'b1;
        model_reset();
        for (int c = 1; c <= 8; c++) begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_release c=%0d got=%h/%h/%b want=%h/%h/%b", c, seg_out, an_out, frame_start, e.seg, e.an, e.fs);
            end
            if (c <= 4) begin
                total++;
                if (frame_start !== (c == 4)) begin
                    bad++;
                    $display("FAIL first_frame_start c=%0d got=%b want=%b", c, frame_start, (c == 4));
                end
            end
        end
    endtask

    task automatic test_scan();
        exp_t e, obs;
        for (int k = 0; k < 6; k++) seg_in[k] = 7'h40 | 7'(k);
        for (int c = 0; c < 60; c++) begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL scan c=%0d got=%h/%h/%b want=%h/%h/%b", c, seg_out, an_out, frame_start, e.seg, e.an, e.fs);
            end
            total++;
            if ($countones(~an_out) > 1) begin
                bad++;
                $display("FAIL scan_onehot c=%0d got=%h want=at most one low bit", c, an_out);
            end
        end
    endtask

    task automatic test_snapshot();
        exp_t e, obs;
        int   guard;
        logic seen_fs;
        seg_in[2] = 7'h79;
        guard = 0;
        do begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin bad++; $display("FAIL snap_pre got=%h/%h/%b want=%h/%h/%b", seg_out, an_out, frame_start, e.seg, e.an, e.fs); end
            guard++;
        end while (!e.fs && guard < 40);
        total++;
        if (guard >= 40) begin bad++; $display("FAIL snap_wait got=no frame_start want=frame_start"); end
        while (m_idx() != 3 && guard < 80) begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin bad++; $display("FAIL snap_mid got=%h/%h/%b want=%h/%h/%b", seg_out, an_out, frame_start, e.seg, e.an, e.fs); end
            guard++;
        end
        seg_in[2] = 7'h24;
        seen_fs = 1'b0;
        for (int c = 0; c < 40; c++) begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin bad++; $display("FAIL snap_post c=%0d got=%h/%h/%b want=%h/%h/%b", c, seg_out, an_out, frame_start, e.seg, e.an, e.fs); end
            if (!seen_fs && an_out == 6'h3B) begin
                total++;
                if (seg_out !== 7'h79) begin bad++; $display("FAIL snap_coherent got=%h want=79", seg_out); end
            end
            if (frame_start) seen_fs = 1'b1;
        end
    endtask

    task automatic test_brightness();
        exp_t e, obs;
        for (int b = 0; b < 2; b++) begin
            brightness = (b == 0) ? 3'd0 : 3'd3;
            for (int c = 0; c < 48; c++) begin
                model_push();
                @(posedge clk); #1;
                e = q.pop_front();
                obs = '{seg_out, an_out, frame_start};
                total++;
                if (obs !== e) begin bad++; $display("FAIL bright%0d c=%0d got=%h/%h/%b want=%h/%h/%b", brightness, c, seg_out, an_out, frame_start, e.seg, e.an, e.fs); end
                if (an_out !== 6'h3F) begin
                    total++;
                    if (m_pwm_last > int'(brightness)) begin bad++; $display("FAIL bright_phase got=pwm %0d want=<=%0d", m_pwm_last, brightness); end
                end
            end
        end
        brightness = 3'd7;
    endtask

    task automatic test_enable();
        exp_t e, obs;
        enable = 1'b0;
        for (int c = 0; c < 30; c++) begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin bad++; $display("FAIL enable_off c=%0d got=%h/%h/%b want=%h/%h/%b", c, seg_out, an_out, frame_start, e.seg, e.an, e.fs); end
            total++;
            if (an_out !== 6'h3F || seg_out !== 7'h7F) begin bad++; $display("FAIL enable_blank got=%h/%h want=3f/7f", an_out, seg_out); end
        end
        enable = 1'b1;
        for (int c = 0; c < 24; c++) begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin bad++; $display("FAIL enable_on c=%0d got=%h/%h/%b want=%h/%h/%b", c, seg_out, an_out, frame_start, e.seg, e.an, e.fs); end
        end
    endtask

    task automatic test_midreset();
        exp_t e, obs;
        int   guard;
        guard = 0;
        while (!(m_idx() == 2 && (m_cnt % CLK_DIV) == 1) && guard < 40) begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin bad++; $display("FAIL mid_pre got=%h/%h/%b want=%h/%h/%b", seg_out, an_out, frame_start, e.seg, e.an, e.fs); end
            guard++;
        end
        total++;
        if (an_out !== 6'h3B) begin bad++; $display("FAIL mid_digit2 got=%h want=3b", an_out); end
        #2 rst = 1'b0;
        #1;
        total++;
        if (an_out !== 6'h3F || seg_out !== 7'h7F || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_blank got=%h/%h/%b want=7f/3f/0", seg_out, an_out, frame_start);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        for (int c = 1; c <= 12; c++) begin
            model_push();
            @(posedge clk); #1;
            e = q.pop_front();
            obs = '{seg_out, an_out, frame_start};
            total++;
            if (obs !== e) begin bad++; $display("FAIL mid_restart c=%0d got=%h/%h/%b want=%h/%h/%b", c, seg_out, an_out, frame_start, e.seg, e.an, e.fs); end
            if (c <= 4) begin
                total++;
                if (frame_start !== (c == 4)) begin bad++; $display("FAIL mid_fs c=%0d got=%b want=%b", c, frame_start, (c == 4)); end
            end
            if (c == 5) begin
                total++;
                if (an_out !== 6'h3E || seg_out !== seg_in[0]) begin
                    bad++;
                    $display("FAIL mid_digit0 got=%h/%h want=3e/%h", an_out, seg_out, seg_in[0]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        brightness = 3'd7;
        for (int k = 0; k < 6; k++) seg_in[k] = 7'h40 | 7'(k);
        model_reset();
        #2 rst = 1'b0;
        test_reset();
        test_scan();
        test_snapshot();
        test_brightness();
        test_enable();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_mux_scan.md
Name: display_mux_scan

Overview:
- Consumer end of the six-digit 7-segment bus produced by the rotating marquee (`saida0..saida5`).
- Takes the six parallel segment patterns and drives them onto one shared segment bus with per-digit anode enables, one digit at a time (time-multiplexed scan).
- Latches a snapshot once per scan frame so a marquee rotation step never tears a frame.
- Adds brightness PWM and inter-digit blanking. Sits between the marquee and the board display pins.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot; must be >= 2.
- BRIGHT_W, 3, width of the brightness input and of the PWM phase counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- seg_in0..seg_in5  in  7 each  active-low segment patterns {g,f,e,d,c,b,a}, as driven by the marquee
- enable  in  1  1 = display on; 0 = all digits blanked, scan keeps running
- brightness  in  BRIGHT_W  duty select; 0 = 1/8 on, 7 = always on
- seg_out  out  7  active-low shared segment bus
- an_out  out  6  active-low digit enables, bit k selects digit k
- frame_start  out  1  one-cycle pulse on each snapshot capture

Behaviour:
- Reset (rst=0, asynchronous):
  - presc=0, idx=5, pwm=0, all six shadow regs=7'h7F.
  - seg_out=7'h7F, an_out=6'h3F, frame_start=0.
- Prescaler:
  - presc counts 0..CLK_DIV-1 and wraps.
  - tick = (presc==CLK_DIV-1), combinational.
- Digit index:
  - On tick, idx advances 0→1→…→5→0.
  - Resetting idx to 5 makes the first tick after reset a frame wrap.
- Snapshot:
  - On the clock edge where tick=1 and idx==5, all six seg_inN are captured into the shadow regs.
  - frame_start is registered high for exactly that one cycle; otherwise it is 0.
  - Input changes at any other time have no visible effect until the next capture.
- PWM:
  - pwm is a free-running BRIGHT_W-bit counter that wraps.
  - lit = (pwm <= brightness).
- Output register, updated every edge, using pre-update idx:
  - If tick=1, or enable=0, or lit=0: an_out<=6'h3F and seg_out<=7'h7F.
  - Otherwise: an_out<=~(6'b1<<idx) and seg_out<=shadow[idx].
- Resulting timing:
  - Outputs show digit idx one cycle after each of slot cycles 0..CLK_DIV-2.
  - The boundary cycle is always blank (anti-ghosting).
  - At most one an_out bit is low at any time.
- Latency: a new seg_in value appears on seg_out no earlier than the first slot of the frame following its capture. Worst case is 2 frames (12·CLK_DIV cycles).
- Boundary conditions:
  - brightness = all ones: never PWM-blanked.
  - enable toggling mid-slot: takes effect on the next edge; counters unaffected.
  - rst asserted mid-frame: immediate blank; shadow contents lost (reset to 7'h7F).
  - tick and capture coincide with the blank cycle, so shadow updates never appear mid-digit.
- Widths:
  - presc is $clog2(CLK_DIV) bits; idx is 3 bits.
  - idx values 6 and 7 are unreachable; if reached, force idx to 0 on the next tick.

Decomposition:
- Shared package, constants only:
  - N_DIGITS=6
  - SEG_BLANK=7'h7F
  - AN_OFF=6'h3F
- One natural sub-module, `tick_divider`, with parameter CLK_DIV, ports clk, rst, tick. It is the prescaler and is reused by the marquee's step timer.
- Index, shadow, PWM and output logic stay in the top.

Test Plan (CLK_DIV=4, brightness=7, enable=1 unless stated):
- Reset: hold rst=0 → seg_out=7'h7F, an_out=6'h3F, frame_start=0. Release rst; at cycle 4 after release, frame_start pulses once.
- Scan order: seg_inN = 7'h40|N, stable. From the second frame onward:
  - an_out cycles 3E,3D,3B,37,2F,1F, each digit low for 3 cycles, then 1 cycle of 3F.
  - seg_out matches seg_inN while digit N is enabled.
- Snapshot coherence: change seg_in2 from 7'h79 to 7'h24 while idx==3.
  - Rest of the frame and the frame's digit 2 still show 7'h79.
  - 7'h24 appears only after the next frame_start.
- Brightness: brightness=0 → an_out low only on cycles where pwm==0, i.e. ≤1 cycle per 8. brightness=3 → on-cycles within digit slots occur only at pwm 0..3.
- enable=0 for 30 cycles → an_out=3F and seg_out=7F throughout. frame_start still pulses every 24 cycles; the scan resumes in phase when enable returns to 1.
- Mid-frame reset: assert rst at idx==2 → outputs blank asynchronously (same cycle). After release, the first frame_start occurs 4 cycles later and the scan restarts at digit 0.
